// File: rtl/redun_mont_pkg.sv
// Shared sizes, helpers and state encoding for the redundant Montgomery datapath.
// redun_collapse resolves redundant msu result words into canonical binary.
package redun_mont_pkg;

  localparam int T_LEN    = 8;
  localparam int WRD_BITS = 4;
  localparam int NUM_WRDS = 4;

  typedef enum logic [1:0] {RECV, DRAIN, PROP, SEND} collapse_state_t;

  function automatic int redun_in_beats(input int t_len, input int wrd_bits,
                                        input int num_wrds, input int axi_len);
    return (t_len + num_wrds * (wrd_bits + 1) + axi_len - 1) / axi_len;
  endfunction

  function automatic int redun_out_w(input int wrd_bits, input int num_wrds);
    return num_wrds * wrd_bits + 2;
  endfunction

  function automatic int redun_out_beats(input int t_len, input int wrd_bits,
                                         input int num_wrds, input int axi_len);
    return (t_len + redun_out_w(wrd_bits, num_wrds) + axi_len - 1) / axi_len;
  endfunction

  // Returns {carry_out[1:0], digit[WRD_BITS-1:0]}; carry stays <= 2 for any input word.
  function automatic logic [WRD_BITS+1:0] carry_step(input logic [WRD_BITS:0] word,
                                                     input logic [1:0] carry);
    return {1'b0, word} + {{WRD_BITS{1'b0}}, carry};
  endfunction

endpackage

// File: rtl/redun_collapse.sv
// Collects a redundant-form frame, resolves it with a serial carry-propagate
// pass and streams {value, count} back out as canonical binary.
module redun_collapse
  import redun_mont_pkg::*;
#(
  parameter int AXI_LEN  = 32,
  parameter int T_LEN    = redun_mont_pkg::T_LEN,
  parameter int WRD_BITS = redun_mont_pkg::WRD_BITS,
  parameter int NUM_WRDS = redun_mont_pkg::NUM_WRDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [AXI_LEN-1:0]   s_axis_tdata,
  input  logic [AXI_LEN/8-1:0] s_axis_tkeep,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [AXI_LEN-1:0]   m_axis_tdata,
  output logic [AXI_LEN/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 frame_err
);

  localparam int IN_BEATS  = redun_in_beats(T_LEN, WRD_BITS, NUM_WRDS, AXI_LEN);
  localparam int IN_BUF_W  = IN_BEATS * AXI_LEN;
  localparam int OUT_W     = redun_out_w(WRD_BITS, NUM_WRDS);
  localparam int OUT_BEATS = redun_out_beats(T_LEN, WRD_BITS, NUM_WRDS, AXI_LEN);
  localparam int OUT_BUF_W = OUT_BEATS * AXI_LEN;
  localparam int MAX_BEATS = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int IDX_W     = $clog2(NUM_WRDS + 1);
  localparam int DIG_W     = NUM_WRDS * WRD_BITS;

  collapse_state_t state, state_nxt;

  logic [CNT_W-1:0]    beat_cnt;
  logic [IDX_W-1:0]    widx;
  logic [1:0]          carry;
  logic [IN_BUF_W-1:0] in_buf;
  logic [OUT_BUF_W-1:0] out_buf;
  logic [DIG_W-1:0]    val;

  logic                in_hs;
  logic                out_hs;
  logic                in_last_beat;
  logic                out_last_beat;
  logic                last_word;
  logic [WRD_BITS:0]   word_cur;
  logic [WRD_BITS+1:0] step;
  logic [OUT_W-1:0]    val_full;
  logic                sink_unused;

  assign s_axis_tready = !rst && (state == RECV || state == DRAIN);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign in_last_beat  = (beat_cnt == CNT_W'(IN_BEATS - 1));
  assign frame_err     = in_hs && s_axis_tlast &&
                         ((state == RECV && !in_last_beat) || state == DRAIN);

  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = out_buf[AXI_LEN-1:0];
  assign m_axis_tkeep  = '1;
  assign out_last_beat = (beat_cnt == CNT_W'(OUT_BEATS - 1));
  assign m_axis_tlast  = (state == SEND) && out_last_beat;
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  // Pad bits above the last word and tkeep carry no information.
  assign sink_unused = ^{s_axis_tkeep, in_buf};

  assign last_word = (widx == IDX_W'(NUM_WRDS - 1));
  assign word_cur  = in_buf[T_LEN + int'(widx) * (WRD_BITS + 1) +: WRD_BITS + 1];
  assign step      = carry_step(word_cur, carry);

  // Value as it stands once the current digit and final carry are folded in.
  always_comb begin
    val_full = {step[WRD_BITS+1:WRD_BITS], val};
    val_full[(NUM_WRDS-1)*WRD_BITS +: WRD_BITS] = step[WRD_BITS-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RECV: begin
        if (in_hs) begin
          if (s_axis_tlast)      state_nxt = in_last_beat ? PROP : RECV;
          else if (in_last_beat) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (in_hs && s_axis_tlast) state_nxt = PROP;
      PROP:    if (last_word) state_nxt = SEND;
      SEND:    if (out_hs && out_last_beat) state_nxt = RECV;
      default: state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RECV;
      beat_cnt <= '0;
      widx     <= '0;
      carry    <= '0;
      in_buf   <= '0;
      out_buf  <= '0;
      val      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // Capture: beats shift in from the top so beat 0 ends at the LSB.
        RECV: begin
          if (in_hs) begin
            if (s_axis_tlast && !in_last_beat) begin
              beat_cnt <= '0;
              in_buf   <= '0;
            end else begin
              in_buf   <= {s_axis_tdata, in_buf[IN_BUF_W-1:AXI_LEN]};
              beat_cnt <= in_last_beat ? '0 : beat_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: ;
        // Carry-propagate: one word per cycle, then load the output frame.
        PROP: begin
          val[int'(widx) * WRD_BITS +: WRD_BITS] <= step[WRD_BITS-1:0];
          if (last_word) begin
            widx    <= '0;
            carry   <= '0;
            out_buf <= OUT_BUF_W'({val_full, in_buf[T_LEN-1:0]});
          end else begin
            widx  <= widx + IDX_W'(1);
            carry <= step[WRD_BITS+1:WRD_BITS];
          end
        end
        // Transmit: shift the frame down one beat per accepted handshake.
        SEND: begin
          if (out_hs) begin
            out_buf  <= out_buf >> AXI_LEN;
            beat_cnt <= out_last_beat ? '0 : beat_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_redun_collapse.sv
// Scoreboard bench for redun_collapse: directed frames in, a monitor compares
// every accepted output beat against queued hand-computed beats.
module tb_redun_collapse;

  localparam int AXI_LEN = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [7:0]   s_axis_tdata;
  logic [0:0]   s_axis_tkeep;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [7:0]   m_axis_tdata;
  logic [0:0]   m_axis_tkeep;
  logic         m_axis_tlast;
  logic         frame_err;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  redun_collapse #(
    .AXI_LEN(AXI_LEN), .T_LEN(8), .WRD_BITS(4), .NUM_WRDS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic [7:0] cnt, input logic [4:0] w0,
                                           input logic [4:0] w1, input logic [4:0] w2,
                                           input logic [4:0] w3);
    logic [63:0] f;
    f = 64'(cnt);
    f = f | (64'(w0) << 8) | (64'(w1) << 13) | (64'(w2) << 18) | (64'(w3) << 23);
    return f;
  endfunction

  task automatic push_beats(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b0, b1});
    exp_q.push_back({1'b0, b2});
    exp_q.push_back({1'b1, b3});
  endtask

  // Drives nbeats beats; tlast on beat tlast_at; frame_err checked on every beat.
  task automatic send_frame(input logic [63:0] bits, input int nbeats,
                            input int tlast_at, input bit err_exp);
    logic [63:0] sh;
    int guard;
    sh = bits;
    @(posedge clk); #1;
    for (int k = 0; k < nbeats; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = sh[7:0];
      s_axis_tlast  = (k == tlast_at);
      sh = sh >> 8;
      guard = 0;
      @(negedge clk);
      while (!s_axis_tready && guard < 100) begin
        @(posedge clk); #1;
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) check("in_ready_timeout", 32'(s_axis_tready), 32'd1);
      check($sformatf("frame_err_beat%0d", k), 32'(frame_err),
            32'(err_exp && (k == tlast_at)));
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_drain_timeout"}, 32'(guard >= 200), 32'd0);
  endtask

  // Monitor: pops expected beats on handshakes, checks stall stability and
  // that tvalid stays up for the whole frame.
  initial begin
    logic       stall_prev;
    logic       in_frame;
    logic [7:0] held_d;
    logic       held_l;
    logic [8:0] e;
    stall_prev = 1'b0;
    in_frame   = 1'b0;
    held_d     = '0;
    held_l     = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) err_seen++;
      if (rst) in_frame = 1'b0;
      if (stall_prev) begin
        check("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("stall_data", 32'(m_axis_tdata), 32'(held_d));
        check("stall_last", 32'(m_axis_tlast), 32'(held_l));
      end else if (in_frame && !rst) begin
        check("valid_mid_frame", 32'(m_axis_tvalid), 32'd1);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready && !rst;
      held_d = m_axis_tdata;
      held_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready && !rst) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data=0x%0h last=%0b expected none",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_axis_tdata), 32'(e[7:0]));
          check("out_last", 32'(m_axis_tlast), 32'(e[8]));
          check("out_keep", 32'(m_axis_tkeep), 32'd1);
        end
        in_frame = !m_axis_tlast;
      end
    end
  end

  initial begin
    logic [63:0] f1, f2;
    int n;
    f1 = mk_frame(8'h05, 5'd1, 5'd2, 5'd3, 5'd4);
    f2 = mk_frame(8'hAA, 5'h1F, 5'h1F, 5'h1F, 5'h1F);

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_axis_tready), 32'd0);
    check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_last", 32'(m_axis_tlast), 32'd0);
    check("rst_m_data", 32'(m_axis_tdata), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_axis_tready), 32'd1);

    // Canonical words, value 0x04321, with output latency check.
    push_beats(8'h05, 8'h21, 8'h43, 8'h00);
    send_frame(f1, 4, 3, 1'b0);
    check("prop_no_ready", 32'(s_axis_tready), 32'd0);
    n = 1;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_latency", 32'(n), 32'd5);
    wait_drain("case1");

    // All 0x1F: carry reaches 2, value 0x2110F.
    push_beats(8'hAA, 8'h0F, 8'h11, 8'h02);
    send_frame(f2, 4, 3, 1'b0);
    wait_drain("case2");

    // Same frame under 1,0,1,0 backpressure.
    push_beats(8'hAA, 8'h0F, 8'h11, 8'h02);
    send_frame(f2, 4, 3, 1'b0);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    m_axis_tready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      m_axis_tready = ~m_axis_tready;
      n++;
    end
    m_axis_tready = 1'b1;
    wait_drain("case3");

    // Early tlast: error pulse, no output, then a clean frame.
    send_frame(f1, 3, 2, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("early_no_output", 32'(m_axis_tvalid), 32'd0);
    push_beats(8'h05, 8'h21, 8'h43, 8'h00);
    send_frame(f1, 4, 3, 1'b0);
    wait_drain("case4");

    // Overlong frame: beats 4 and 5 dropped, error on beat 5.
    push_beats(8'h05, 8'h21, 8'h43, 8'h00);
    send_frame(f1 | (64'hFFFF << 32), 6, 5, 1'b1);
    wait_drain("case5");

    // Reset during output beat 1.
    exp_q.push_back({1'b0, 8'hAA});
    send_frame(f2, 4, 3, 1'b0);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_send_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_send_last", 32'(m_axis_tlast), 32'd0);
    check("rst_send_queue", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    push_beats(8'hAA, 8'h0F, 8'h11, 8'h02);
    send_frame(f2, 4, 3, 1'b0);
    wait_drain("case6");

    check("frame_err_pulses", 32'(err_seen), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
